instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, which is the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port imem_addr, output, 8 bits: byte address to instruction memory.
REQ-005 SHALL have port imem_data, input, 8 bits: memory byte at imem_addr, combinational in the same cycle.
REQ-006 SHALL have port instr_valid, output, 1 bit: decoded instruction presented.
REQ-007 SHALL have port instr_ready, input, 1 bit: consumer accepts the instruction.
REQ-008 SHALL have port instr_opcode, output, 8 bits: first instruction byte.
REQ-009 SHALL have port instr_imm, output, 8 bits: second byte for two-byte instructions, else 8'h00.
REQ-010 SHALL have port instr_pc, output, 8 bits: address of the opcode byte.
REQ-011 SHALL have port instr_len2, output, 1 bit: 1 means two-byte instruction.
REQ-012 SHALL have port redirect_valid, input, 1 bit: load new fetch address.
REQ-013 SHALL have port redirect_addr, input, 8 bits: new fetch address.
REQ-014 SHALL have port halted, output, 1 bit: HLT accepted; fetch stopped.

Function
REQ-015 SHALL implement states FETCH_OP, FETCH_IMM, HOLD, HALTED.
REQ-016 SHALL, in FETCH_OP: drive imem_addr=pc; latch imem_data into opcode and pc into instr_pc; set pc<=pc+1; go to FETCH_IMM if two-byte, else HOLD.
REQ-017 SHALL treat an instruction as two-byte iff opcode[7:4]==4'b1001 (LOAD immediate); all other opcodes are one-byte.
REQ-018 SHALL, in FETCH_IMM: drive imem_addr=pc; latch imem_data into imm; set pc<=pc+1; go to HOLD.
REQ-019 SHALL assert instr_valid only in HOLD and hold opcode/imm/pc/len2 stable until instr_valid && instr_ready.
REQ-020 SHALL, on handshake in HOLD, go to HALTED if opcode==8'b11110000 (HLT), else to FETCH_OP.
REQ-021 SHALL give latency: one-byte instruction valid 1 cycle after entering FETCH_OP; two-byte after 2; back-to-back throughput 1 instr / 2 cycles (one-byte) or 3 cycles (two-byte) with ready held high.
REQ-022 SHALL wrap pc modulo 256 (8'hFF+1=8'h00); a two-byte instruction at 8'hFF takes its immediate from 8'h00.
REQ-023 SHALL give redirect_valid priority in FETCH_OP, FETCH_IMM, HOLD: pc<=redirect_addr, discard partial/held instruction, next state FETCH_OP, instr_valid low next cycle.
REQ-024 SHALL, when redirect and handshake coincide in HOLD, count the held instruction as consumed and then apply the redirect; HLT plus redirect in the same cycle goes to HALTED and the redirect is ignored.
REQ-025 SHALL ignore redirect_valid and instr_ready in HALTED; halted=1, instr_valid=0, imem_addr=pc.
REQ-026 SHALL drive imem_addr=pc in HOLD.
REQ-027 SHALL clear imm to 8'h00 when a one-byte opcode is latched.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set state=FETCH_OP, pc=RESET_PC, instr_valid=0, instr_opcode=8'h00, instr_imm=8'h00, instr_pc=8'h00, instr_len2=0, halted=0.
REQ-029 SHALL make reset override all inputs, including reset mid-FETCH_IMM or in HALTED; the first fetch is from RESET_PC on the cycle after rst deasserts.

Structure
REQ-030 SHALL place opcode constants (OP_LOAD nibble 4'b1001, OP_SUB nibble 4'b0010, OP_HLT 8'b11110000), the state encoding, and an is_two_byte(opcode) function in the shared cpu package.
REQ-031 SHALL be a single module without sub-modules; the bench instantiates instruction_memory as the responder.

Verification
REQ-032 SHALL cover: memory 90 0A 94 0B 29 F0, ready=1 -> (pc00, 90, 0A, len2=1), (pc02, 94, 0B, len2=1), (pc04, 29, 00, len2=0), (pc05, F0); halted=1 one cycle after the F0 handshake.
REQ-033 SHALL cover: ready=0 for 5 cycles in HOLD on 94 0B -> outputs stable and pc=04 throughout; one handshake on release.
REQ-034 SHALL cover: redirect_valid with redirect_addr=8'h04 during FETCH_IMM of 90 -> no instruction emitted for pc00; next instruction (pc04, 29).
REQ-035 SHALL cover: RESET_PC=8'hFF, mem[FF]=90, mem[00]=55 -> (pcFF, 90, 55); next fetch from 8'h01.
REQ-036 SHALL cover: rst pulse while halted -> halted=0, instr_valid=0, re-fetch from RESET_PC, same sequence as REQ-032.
REQ-037 SHALL cover: handshake plus redirect(8'h02) in HOLD of 29 -> 29 consumed once; next instruction (pc02, 94, 0B).

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared cpu definitions: opcode constants, fetch FSM encoding and instruction length decode.
package instruction_fetch_pkg;

    localparam logic [3:0] OP_LOAD = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [7:0] OP_HLT  = 8'b11110000;

    typedef enum logic [1:0] {
        StFetchOp,
        StFetchImm,
        StHold,
        StHalted
    } fetch_state_e;

    // LOAD immediate is the only instruction carrying a second byte.
    function automatic logic is_two_byte(input logic [7:0] opcode);
        return opcode[7:4] == OP_LOAD;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: gathers one- or two-byte instructions from a combinational
// memory and presents them on a valid/ready interface, with redirect and halt support.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_imm,
    output logic [7:0] instr_pc,
    output logic       instr_len2,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    output logic       halted
);

    fetch_state_e state_q;
    logic [7:0]   pc_q;
    logic [7:0]   opcode_q;
    logic [7:0]   imm_q;
    logic [7:0]   ipc_q;
    logic         len2_q;
    logic         valid_q;
    logic         halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFetchOp;
            pc_q     <= RESET_PC;
            opcode_q <= 8'h00;
            imm_q    <= 8'h00;
            ipc_q    <= 8'h00;
            len2_q   <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFetchOp: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_addr;
                    end else begin
                        opcode_q <= imem_data;
                        ipc_q    <= pc_q;
                        pc_q     <= pc_q + 8'd1;
                        len2_q   <= is_two_byte(imem_data);
                        if (is_two_byte(imem_data)) begin
                            state_q <= StFetchImm;
                        end else begin
                            imm_q   <= 8'h00;
                            valid_q <= 1'b1;
                            state_q <= StHold;
                        end
                    end
                end
                StFetchImm: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_addr;
                        state_q <= StFetchOp;
                    end else begin
                        imm_q   <= imem_data;
                        pc_q    <= pc_q + 8'd1;
                        valid_q <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    // The handshake wins: the held instruction is consumed before any redirect.
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (opcode_q == OP_HLT) begin
                            halted_q <= 1'b1;
                            state_q  <= StHalted;
                        end else begin
                            state_q <= StFetchOp;
                            if (redirect_valid) begin
                                pc_q <= redirect_addr;
                            end
                        end
                    end else if (redirect_valid) begin
                        valid_q <= 1'b0;
                        pc_q    <= redirect_addr;
                        state_q <= StFetchOp;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: state_q <= StFetchOp;
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign instr_valid  = valid_q;
    assign instr_opcode = opcode_q;
    assign instr_imm    = imm_q;
    assign instr_pc     = ipc_q;
    assign instr_len2   = len2_q;
    assign halted       = halted_q;

endmodule
